iq_channel_xbar: RTL and testbench

IQ_CHANNEL_XBAR -- requirements
Module: iq_channel_xbar

---
 rtl/iq_channel_xbar.sv | 202 ++++++++++++++++++++
 tb/tb_iq_channel_xbar.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_channel_xbar.sv
// -----------------------------------------------------------------------------
// iq_channel_xbar
//
// NCH x NCH crossbar for I/Q sample streams. Each output k is fed from the
// input channel named by its route field (field value >= NCH mutes that output).
// A route change is requested with i_route_wr. It is held pending until a
// frame pulse arrives on one of the new sources, or until a timeout expires.
// Only the outputs whose source changes are then blanked for BLANK_CYC cycles.
// After the blank the new routing is applied and o_ack pulses.
// All outputs are registered: data latency is exactly one clock.
//
// Ports
//   i_clk_125p          system clock (rising edge)
//   i_rst_n             asynchronous active-low reset
//   i_idata / i_qdata   NCH packed I/Q samples, channel n at [n*DW +: DW]
//   i_fp                per-channel frame pulse
//   i_route_sel         NCH packed route fields (SW bits each), field k -> output k
//   i_route_wr          one-cycle request to load i_route_sel
//   o_idata / o_qdata   routed I/Q samples, same packing as the inputs
//   o_fp                routed frame pulses
//   o_busy              route change in progress
//   o_ack               one-cycle pulse when the new route takes effect
//   o_tmo               sticky: last change was forced by timeout
//   o_err               sticky: a write was rejected while busy
// -----------------------------------------------------------------------------
module iq_channel_xbar #(
  parameter int DW        = 12,
  parameter int NCH       = 4,
  parameter int SW        = 3,
  parameter int BLANK_CYC = 4,
  parameter int TMO_CYC   = 65535
) (
  input  logic                i_clk_125p,
  input  logic                i_rst_n,
  input  logic [NCH*DW-1:0]   i_idata,
  input  logic [NCH*DW-1:0]   i_qdata,
  input  logic [NCH-1:0]      i_fp,
  input  logic [NCH*SW-1:0]   i_route_sel,
  input  logic                i_route_wr,
  output logic [NCH*DW-1:0]   o_idata,
  output logic [NCH*DW-1:0]   o_qdata,
  output logic [NCH-1:0]      o_fp,
  output logic                o_busy,
  output logic                o_ack,
  output logic                o_tmo,
  output logic                o_err
);

  // Timeout counter runs 0..TMO_CYC-1 while waiting for a frame pulse.
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int BW = 8;

  function automatic logic [NCH*SW-1:0] f_identity();
    logic [NCH*SW-1:0] m;
    m = '0;
    for (int k = 0; k < NCH; k++) begin
      m[k*SW +: SW] = SW'(k);
    end
    return m;
  endfunction

  localparam logic [NCH*SW-1:0] IDENT = f_identity();

  typedef enum logic [1:0] {IDLE, WAIT_FP, BLANK, APPLY} state_t;

  state_t              r_state;
  logic [NCH*SW-1:0]   r_act;
  logic [NCH*SW-1:0]   r_pend;
  logic [TW-1:0]       r_tmo_cnt;
  logic [BW-1:0]       r_blank_cnt;
  logic                r_busy;
  logic                r_ack;
  logic                r_tmo;
  logic                r_err;

  logic [NCH-1:0]      w_src_ok;   // pending field k names a real input
  logic [NCH-1:0]      w_fp_hit;   // frame pulse seen on pending source k
  logic                w_trigger;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_out
      logic [SW-1:0] w_pend_f;
      logic [SW-1:0] w_act_f;
      logic [SW-1:0] w_sel_f;
      logic          w_blank;
      logic [DW-1:0] w_i_mux;
      logic [DW-1:0] w_q_mux;
      logic          w_fp_mux;
      logic [DW-1:0] r_i;
      logic [DW-1:0] r_q;
      logic          r_fp;

      assign w_pend_f     = r_pend[gi*SW +: SW];
      assign w_act_f      = r_act[gi*SW +: SW];
      assign w_src_ok[gi] = (w_pend_f < SW'(NCH));
      // Shifting past NCH yields zero, so muted fields never hit.
      assign w_fp_hit[gi] = |(i_fp & (NCH'(1) << w_pend_f));

      // In APPLY the new route is already used so the output register loads
      // the new source in the same edge that raises o_ack (no stale cycle).
      assign w_sel_f = (r_state == APPLY) ? w_pend_f : w_act_f;
      assign w_blank = (r_state == BLANK) && (w_pend_f != w_act_f);

      // AND-OR mux; a select >= NCH matches nothing and mutes the output.
      always_comb begin
        w_i_mux  = '0;
        w_q_mux  = '0;
        w_fp_mux = 1'b0;
        for (int s = 0; s < NCH; s++) begin
          if (w_sel_f == SW'(s)) begin
            w_i_mux  = i_idata[s*DW +: DW];
            w_q_mux  = i_qdata[s*DW +: DW];
            w_fp_mux = i_fp[s];
          end
        end
      end

      always_ff @(posedge i_clk_125p or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_i  <= '0;
          r_q  <= '0;
          r_fp <= 1'b0;
        end else begin
          r_i  <= w_blank ? '0   : w_i_mux;
          r_q  <= w_blank ? '0   : w_q_mux;
          r_fp <= w_blank ? 1'b0 : w_fp_mux;
        end
      end

      assign o_idata[gi*DW +: DW] = r_i;
      assign o_qdata[gi*DW +: DW] = r_q;
      assign o_fp[gi]             = r_fp;
    end
  endgenerate

  // With every pending output muted there is no source to sync to, so the
  // change is timed from channel 0 instead.
  assign w_trigger = (|w_src_ok) ? (|w_fp_hit) : i_fp[0];

  always_ff @(posedge i_clk_125p or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_act       <= IDENT;
      r_pend      <= IDENT;
      r_tmo_cnt   <= '0;
      r_blank_cnt <= '0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_tmo       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (i_route_wr && (r_state != IDLE)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_route_wr) begin
            r_pend    <= i_route_sel;
            r_tmo     <= 1'b0;
            r_busy    <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= WAIT_FP;
          end
        end
        WAIT_FP: begin
          if (w_trigger) begin
            r_blank_cnt <= '0;
            r_state     <= BLANK;
          end else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
            r_tmo       <= 1'b1;
            r_blank_cnt <= '0;
            r_state     <= BLANK;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (r_blank_cnt == BW'(BLANK_CYC - 1)) begin
            r_state <= APPLY;
          end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
          end
        end
        APPLY: begin
          r_act   <= r_pend;
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_ack  = r_ack;
  assign o_tmo  = r_tmo;
  assign o_err  = r_err;

endmodule

// File: tb/tb_iq_channel_xbar.sv
// -----------------------------------------------------------------------------
// tb_iq_channel_xbar
//
// Drives directed and random traffic into iq_channel_xbar. For every clock the
// driver computes the expected registered outputs from a timeline model of a
// route change (write cycle, trigger cycle, blank window, apply cycle) and
// pushes them to a scoreboard queue. An independent monitor pops one entry
// per clock and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_iq_channel_xbar;

  localparam int DW        = 12;
  localparam int NCH       = 4;
  localparam int SW        = 3;
  localparam int BLANK_CYC = 4;
  localparam int TMO_CYC   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH*DW-1:0]   i_idata = '0;
  logic [NCH*DW-1:0]   i_qdata = '0;
  logic [NCH-1:0]      i_fp = '0;
  logic [NCH*SW-1:0]   i_route_sel = '0;
  logic                i_route_wr = 1'b0;
  logic [NCH*DW-1:0]   o_idata;
  logic [NCH*DW-1:0]   o_qdata;
  logic [NCH-1:0]      o_fp;
  logic                o_busy;
  logic                o_ack;
  logic                o_tmo;
  logic                o_err;

  iq_channel_xbar #(
    .DW(DW), .NCH(NCH), .SW(SW), .BLANK_CYC(BLANK_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .i_clk_125p (clk),
    .i_rst_n    (rst_n),
    .i_idata    (i_idata),
    .i_qdata    (i_qdata),
    .i_fp       (i_fp),
    .i_route_sel(i_route_sel),
    .i_route_wr (i_route_wr),
    .o_idata    (o_idata),
    .o_qdata    (o_qdata),
    .o_fp       (o_fp),
    .o_busy     (o_busy),
    .o_ack      (o_ack),
    .o_tmo      (o_tmo),
    .o_err      (o_err)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [NCH*DW-1:0] id;
    logic [NCH*DW-1:0] qd;
    logic [NCH-1:0]    fp;
    logic              busy;
    logic              ack;
    logic              tmo;
    logic              err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: current and pending source per output, plus the cycle
  // numbers that define an in-flight change.
  int m_act[NCH];
  int m_pend[NCH];
  bit m_chg;
  int m_w;
  int m_trig;
  bit m_tmo;
  bit m_err;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, a, x, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_act[k]  = k;
      m_pend[k] = k;
    end
    m_chg  = 1'b0;
    m_trig = -1;
    m_tmo  = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic bit fp_qual(input logic [NCH-1:0] fp);
    bit any_valid = 1'b0;
    bit hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (m_pend[k] < NCH) begin
        any_valid = 1'b1;
        if (fp[m_pend[k]]) hit = 1'b1;
      end
    end
    return any_valid ? hit : fp[0];
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_d();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[NCH*DW-1:0];
  endfunction

  function automatic logic [NCH*SW-1:0] mk_sel(input int s0, input int s1, input int s2, input int s3);
    logic [NCH*SW-1:0] r;
    r = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    return r;
  endfunction

  function automatic logic [NCH-1:0] rnd_fp(input int pct);
    logic [NCH-1:0] f;
    for (int k = 0; k < NCH; k++) f[k] = ($urandom_range(0, 99) < pct);
    return f;
  endfunction

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic step(input logic [NCH*DW-1:0] id, input logic [NCH*DW-1:0] qd,
                      input logic [NCH-1:0] fp, input logic [NCH*SW-1:0] sel,
                      input logic wr);
    exp_t e;
    int   route[NCH];
    bit   blank[NCH];
    i_idata     = id;
    i_qdata     = qd;
    i_fp        = fp;
    i_route_sel = sel;
    i_route_wr  = wr;
    e.busy = 1'b0;
    e.ack  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      route[k] = m_act[k];
      blank[k] = 1'b0;
    end
    if (!m_chg) begin
      if (wr) begin
        m_chg  = 1'b1;
        m_w    = cyc;
        m_trig = -1;
        m_tmo  = 1'b0;
        for (int k = 0; k < NCH; k++) m_pend[k] = int'(sel[k*SW +: SW]);
      end
      e.busy = m_chg;
    end else begin
      if (wr) m_err = 1'b1;
      if (m_trig < 0) begin
        if (fp_qual(fp)) begin
          m_trig = cyc;
        end else if (cyc - m_w == TMO_CYC) begin
          m_trig = cyc;
          m_tmo  = 1'b1;
        end
        e.busy = 1'b1;
      end else if (cyc <= m_trig + BLANK_CYC) begin
        for (int k = 0; k < NCH; k++) blank[k] = (m_pend[k] != m_act[k]);
        e.busy = 1'b1;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          route[k] = m_pend[k];
          m_act[k] = m_pend[k];
        end
        m_chg = 1'b0;
        e.ack = 1'b1;
      end
    end
    e.tmo = m_tmo;
    e.err = m_err;
    e.id  = '0;
    e.qd  = '0;
    e.fp  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!blank[k] && route[k] < NCH) begin
        e.id[k*DW +: DW] = id[route[k]*DW +: DW];
        e.qd[k*DW +: DW] = qd[route[k]*DW +: DW];
        e.fp[k]          = fp[route[k]];
      end
    end
    sb_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input int fp_pct);
    for (int i = 0; i < n; i++) step(rnd_d(), rnd_d(), rnd_fp(fp_pct), '0, 1'b0);
  endtask

  task automatic wr_route(input logic [NCH*SW-1:0] sel);
    $display("[TB] route write sel=%h at t=%0t", sel, $time);
    step(rnd_d(), rnd_d(), '0, sel, 1'b1);
  endtask

  task automatic pulse(input logic [NCH-1:0] fp);
    step(rnd_d(), rnd_d(), fp, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst_n      = 1'b0;
      i_route_wr = 1'b0;
      i_idata    = rnd_d();
      i_qdata    = rnd_d();
      model_reset();
      e.id = '0; e.qd = '0; e.fp = '0;
      e.busy = 1'b0; e.ack = 1'b0; e.tmo = 1'b0; e.err = 1'b0;
      sb_q.push_back(e);
      cyc++;
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // Monitor: one scoreboard entry per clock, sampled after the edge settles.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("o_idata", 64'(o_idata), 64'(e.id));
      chk("o_qdata", 64'(o_qdata), 64'(e.qd));
      chk("o_fp",    64'(o_fp),    64'(e.fp));
      chk("o_busy",  64'(o_busy),  64'(e.busy));
      chk("o_ack",   64'(o_ack),   64'(e.ack));
      chk("o_tmo",   64'(o_tmo),   64'(e.tmo));
      chk("o_err",   64'(o_err),   64'(e.err));
      if (o_ack) $display("[TB] route ack at t=%0t", $time);
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Identity routing with the 0x100+n pattern, then random traffic.
    for (int i = 0; i < 4; i++) begin
      step({12'h103, 12'h102, 12'h101, 12'h100}, rnd_d(), rnd_fp(50), '0, 1'b0);
    end
    run(8, 20);

    // Swap outputs 2 and 3, synchronised to a frame pulse on channel 3.
    wr_route(mk_sel(0, 1, 3, 2));
    run(3, 0);
    pulse(4'b1000);
    run(8, 0);

    // Back to identity with no frame pulse: forced switch after timeout.
    wr_route(mk_sel(0, 1, 2, 3));
    run(TMO_CYC + BLANK_CYC + 6, 0);

    // Second write while busy is rejected; first route is applied.
    wr_route(mk_sel(1, 0, 2, 3));
    run(2, 0);
    step(rnd_d(), rnd_d(), '0, mk_sel(3, 3, 3, 3), 1'b1);
    run(2, 0);
    pulse(4'b0001);
    run(8, 0);

    // Mute output 0, broadcast channel 0 to outputs 1..3.
    wr_route(mk_sel(7, 0, 0, 0));
    run(2, 0);
    pulse(4'b0001);
    run(8, 0);
    run(5, 30);

    // Write equal to the active route: nothing blanked, ack still pulses.
    wr_route(mk_sel(7, 0, 0, 0));
    pulse(4'b0001);
    run(7, 0);

    // All outputs muted: only channel 0 can time the change.
    wr_route(mk_sel(4, 5, 6, 7));
    pulse(4'b0100);
    pulse(4'b0001);
    run(BLANK_CYC + 1, 0);

    // Write accepted in the cycle o_ack is visible.
    wr_route(mk_sel(0, 1, 2, 3));
    pulse(4'b0001);
    run(BLANK_CYC + 1, 0);
    wr_route(mk_sel(2, 2, 1, 1));
    pulse(4'b0010);
    run(8, 10);

    // Reset in the middle of the blank window aborts the change.
    wr_route(mk_sel(3, 2, 1, 0));
    pulse(4'b0001);
    run(2, 0);
    do_reset(2);
    run(10, 30);

    // Random traffic with random route writes, including busy-time writes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(rnd_d(), rnd_d(), rnd_fp(15),
             mk_sel($urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7)), 1'b1);
      end else begin
        step(rnd_d(), rnd_d(), rnd_fp(15), '0, 1'b0);
      end
    end
    run(30, 20);

    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
